// File: rtl/axis_route_1to3_if.sv
// AXI4-Stream bundle used on both sides of the 1-to-3 router.
// LANES packs several parallel streams side by side; the slave side of the
// router uses a single lane, the master side uses three.
interface axis_route_1to3_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 2,
    parameter int LANES      = 1
);
    logic [LANES-1:0]              tvalid;
    logic [LANES-1:0]              tready;
    logic [LANES*DATA_WIDTH-1:0]   tdata;
    logic [LANES*DATA_WIDTH/8-1:0] tkeep;
    logic [LANES-1:0]              tlast;
    logic [DEST_WIDTH-1:0]         tdest;

    modport master (
        output tvalid, tdata, tkeep, tlast, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tdest,
        output tready
    );
endinterface

// File: rtl/axis_route_1to3.sv
// Packet router: one AXI4-Stream input fanned out to three output lanes.
// The destination is latched from tdest on the first beat of each packet and
// held until tlast. Packets to an out-of-range or disabled lane are swallowed
// and counted. Every output lane is a one-entry registered slice.
module axis_route_1to3 #(
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 2
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    axis_route_1to3_if.slave        s_axis,
    axis_route_1to3_if.master       m_axis,
    input  logic [2:0]              m_dest_enable,
    output logic                    s_decode_err,
    output logic [15:0]             drop_count
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int NUM_LANES  = 3;

    typedef enum logic [1:0] {
        IDLE,
        ROUTE,
        DROP
    } state_e;

    state_e                          state_q, state_d;
    logic [1:0]                      sel_q, sel_d;
    logic [NUM_LANES-1:0]            valid_q;
    logic [NUM_LANES*DATA_WIDTH-1:0] data_q;
    logic [NUM_LANES*KEEP_WIDTH-1:0] keep_q;
    logic [NUM_LANES-1:0]            last_q;
    logic                            err_q;
    logic [15:0]                     drop_q;

    logic [NUM_LANES-1:0]            slotFree;
    logic                            destOk;
    logic                            routing;
    logic [1:0]                      target;
    logic                            sReady;
    logic                            accept;
    logic                            dropFirst;
    logic [NUM_LANES-1:0]            load;

    assign slotFree = ~valid_q | m_axis.tready;

    // Decode the destination, pick the target slot and work out readiness,
    // slot loads and the next state for the current beat.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        destOk    = 1'b0;
        routing   = 1'b0;
        target    = sel_q;
        sReady    = 1'b0;
        accept    = 1'b0;
        dropFirst = 1'b0;
        load      = '0;

        for (int i = 0; i < NUM_LANES; i++) begin
            if (s_axis.tdest == DEST_WIDTH'(i)) begin
                destOk = m_dest_enable[i];
            end
        end

        case (state_q)
            IDLE: begin
                if (destOk) begin
                    routing = 1'b1;
                    target  = s_axis.tdest[1:0];
                    sReady  = slotFree[target];
                end else begin
                    sReady = 1'b1;
                end
            end
            ROUTE: begin
                routing = 1'b1;
                sReady  = slotFree[sel_q];
            end
            DROP: begin
                sReady = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!aresetn) begin
            sReady = 1'b0;
        end

        accept = s_axis.tvalid && sReady;

        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (destOk) begin
                        sel_d   = target;
                        state_d = s_axis.tlast ? IDLE : ROUTE;
                    end else begin
                        dropFirst = 1'b1;
                        state_d   = s_axis.tlast ? IDLE : DROP;
                    end
                end
                ROUTE, DROP: begin
                    if (s_axis.tlast) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (accept && routing) begin
            load = NUM_LANES'(3'b001 << target);
        end
    end

    // Packet state and the lane latched from the first beat.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // One-entry output slice per lane: load on a routed beat, empty when taken.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            valid_q <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (load[i]) begin
                    valid_q[i]                           <= 1'b1;
                    data_q[i*DATA_WIDTH +: DATA_WIDTH]   <= s_axis.tdata;
                    keep_q[i*KEEP_WIDTH +: KEEP_WIDTH]   <= s_axis.tkeep;
                    last_q[i]                            <= s_axis.tlast;
                end else if (m_axis.tready[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Error pulse and saturating count for each discarded packet.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            err_q  <= 1'b0;
            drop_q <= 16'd0;
        end else begin
            err_q <= dropFirst;
            if (dropFirst && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    assign s_axis.tready = sReady;
    assign m_axis.tvalid = valid_q;
    assign m_axis.tdata  = data_q;
    assign m_axis.tkeep  = keep_q;
    assign m_axis.tlast  = last_q;
    // Output lanes carry no further routing information.
    assign m_axis.tdest  = '0;
    assign s_decode_err  = err_q;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_axis_route_1to3.sv
// Directed bench for the 1-to-3 AXI4-Stream router: a cycle-by-cycle vector
// table followed by an in-order delivery run under lane back-pressure and a
// drop-counter saturation run.
module tb_axis_route_1to3;

    logic        aclk;
    logic        aresetn;
    logic [2:0]  m_dest_enable;
    logic        s_decode_err;
    logic [15:0] drop_count;

    int nChecks = 0;
    int nFails  = 0;

    axis_route_1to3_if #(.DATA_WIDTH(32), .DEST_WIDTH(2), .LANES(1)) s_if ();
    axis_route_1to3_if #(.DATA_WIDTH(32), .DEST_WIDTH(2), .LANES(3)) m_if ();

    axis_route_1to3 #(.DATA_WIDTH(32), .DEST_WIDTH(2)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .m_dest_enable (m_dest_enable),
        .s_decode_err  (s_decode_err),
        .drop_count    (drop_count)
    );

    // 100 MHz clock.
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    typedef struct {
        logic        rstn;
        logic        v;
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic [1:0]  dest;
        logic [2:0]  mr;
        logic [2:0]  en;
        logic        expSr;
        logic [2:0]  expMv;
        logic [2:0]  expMl;
        logic [31:0] expD;
        logic [3:0]  expK;
        logic        expErr;
        logic [15:0] expCnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rstn, input logic v, input logic [31:0] d,
                                input logic [3:0] k, input logic l, input logic [1:0] dest,
                                input logic [2:0] mr, input logic [2:0] en,
                                input logic sr, input logic [2:0] mv, input logic [2:0] ml,
                                input logic [31:0] ed, input logic [3:0] ek,
                                input logic err, input logic [15:0] cnt);
        vec_t r;
        r.rstn = rstn; r.v = v; r.d = d; r.k = k; r.l = l; r.dest = dest;
        r.mr = mr; r.en = en; r.expSr = sr; r.expMv = mv; r.expMl = ml;
        r.expD = ed; r.expK = ek; r.expErr = err; r.expCnt = cnt;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t r);
        @(posedge aclk);
        #1;
        aresetn        = r.rstn;
        s_if.tvalid    = r.v;
        s_if.tdata     = r.d;
        s_if.tkeep     = r.k;
        s_if.tlast     = r.l;
        s_if.tdest     = r.dest;
        m_if.tready    = r.mr;
        m_dest_enable  = r.en;
    endtask

    task automatic checkRow(input int idx, input vec_t r);
        checkOutput($sformatf("row%0d s_tready", idx), 32'(s_if.tready), 32'(r.expSr));
        checkOutput($sformatf("row%0d m_tvalid", idx), 32'(m_if.tvalid), 32'(r.expMv));
        checkOutput($sformatf("row%0d decode_err", idx), 32'(s_decode_err), 32'(r.expErr));
        checkOutput($sformatf("row%0d drop_count", idx), 32'(drop_count), 32'(r.expCnt));
        for (int i = 0; i < 3; i++) begin
            if (r.expMv[i]) begin
                checkOutput($sformatf("row%0d lane%0d tdata", idx, i), m_if.tdata[i*32 +: 32], r.expD);
                checkOutput($sformatf("row%0d lane%0d tkeep", idx, i), 32'(m_if.tkeep[i*4 +: 4]), 32'(r.expK));
                checkOutput($sformatf("row%0d lane%0d tlast", idx, i), 32'(m_if.tlast[i]), 32'(r.expMl[i]));
            end
        end
    endtask

    initial begin
        logic [7:0] readyPat;
        int sent;
        int rcv;
        int cyc;

        aresetn       = 1'b0;
        s_if.tvalid   = 1'b0;
        s_if.tdata    = '0;
        s_if.tkeep    = '0;
        s_if.tlast    = 1'b0;
        s_if.tdest    = '0;
        m_if.tready   = 3'b111;
        m_dest_enable = 3'b111;

        // rstn v data keep last dest mr en | sr mv ml data keep err cnt
        // 4-beat packet to lane 1
        vecs.push_back(mk(1, 1, 32'h11111111, 4'hF, 0, 1, 3'b111, 3'b111, 1, 3'b000, 3'b000, 32'h0, 4'h0, 0, 0));
        vecs.push_back(mk(1, 1, 32'h11111112, 4'h3, 0, 0, 3'b111, 3'b111, 1, 3'b010, 3'b000, 32'h11111111, 4'hF, 0, 0));
        vecs.push_back(mk(1, 1, 32'h11111113, 4'h1, 0, 0, 3'b111, 3'b111, 1, 3'b010, 3'b000, 32'h11111112, 4'h3, 0, 0));
        vecs.push_back(mk(1, 1, 32'h11111114, 4'h8, 1, 0, 3'b111, 3'b111, 1, 3'b010, 3'b000, 32'h11111113, 4'h1, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,        4'hF, 0, 0, 3'b111, 3'b111, 1, 3'b010, 3'b010, 32'h11111114, 4'h8, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,        4'hF, 0, 0, 3'b111, 3'b111, 1, 3'b000, 3'b000, 32'h0, 4'h0, 0, 0));
        // single-beat packets to lanes 0, 2, 1 back to back
        vecs.push_back(mk(1, 1, 32'hA0A0A0A0, 4'h7, 1, 0, 3'b111, 3'b111, 1, 3'b000, 3'b000, 32'h0, 4'h0, 0, 0));
        vecs.push_back(mk(1, 1, 32'hA2A2A2A2, 4'hF, 1, 2, 3'b111, 3'b111, 1, 3'b001, 3'b001, 32'hA0A0A0A0, 4'h7, 0, 0));
        vecs.push_back(mk(1, 1, 32'hA1A1A1A1, 4'hF, 1, 1, 3'b111, 3'b111, 1, 3'b100, 3'b100, 32'hA2A2A2A2, 4'hF, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,        4'hF, 0, 0, 3'b111, 3'b111, 1, 3'b010, 3'b010, 32'hA1A1A1A1, 4'hF, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,        4'hF, 0, 0, 3'b111, 3'b111, 1, 3'b000, 3'b000, 32'h0, 4'h0, 0, 0));
        // lane 2 stalled: lane 0 beat first, then a 3-beat packet to lane 2
        vecs.push_back(mk(1, 1, 32'hC0C0C0C0, 4'hF, 1, 0, 3'b011, 3'b111, 1, 3'b000, 3'b000, 32'h0, 4'h0, 0, 0));
        vecs.push_back(mk(1, 1, 32'hB1B1B1B1, 4'hF, 0, 2, 3'b011, 3'b111, 1, 3'b001, 3'b001, 32'hC0C0C0C0, 4'hF, 0, 0));
        vecs.push_back(mk(1, 1, 32'hB2B2B2B2, 4'hF, 0, 0, 3'b011, 3'b111, 0, 3'b100, 3'b000, 32'hB1B1B1B1, 4'hF, 0, 0));
        vecs.push_back(mk(1, 1, 32'hB2B2B2B2, 4'hF, 0, 0, 3'b011, 3'b111, 0, 3'b100, 3'b000, 32'hB1B1B1B1, 4'hF, 0, 0));
        vecs.push_back(mk(1, 1, 32'hB2B2B2B2, 4'hF, 0, 0, 3'b111, 3'b111, 1, 3'b100, 3'b000, 32'hB1B1B1B1, 4'hF, 0, 0));
        vecs.push_back(mk(1, 1, 32'hB3B3B3B3, 4'hF, 1, 0, 3'b111, 3'b111, 1, 3'b100, 3'b000, 32'hB2B2B2B2, 4'hF, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,        4'hF, 0, 0, 3'b111, 3'b111, 1, 3'b100, 3'b100, 32'hB3B3B3B3, 4'hF, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,        4'hF, 0, 0, 3'b111, 3'b111, 1, 3'b000, 3'b000, 32'h0, 4'h0, 0, 0));
        // tdest=3 packet dropped, then a packet to disabled lane 1
        vecs.push_back(mk(1, 1, 32'hD1D1D1D1, 4'hF, 0, 3, 3'b111, 3'b111, 1, 3'b000, 3'b000, 32'h0, 4'h0, 0, 0));
        vecs.push_back(mk(1, 1, 32'hD2D2D2D2, 4'hF, 0, 0, 3'b111, 3'b111, 1, 3'b000, 3'b000, 32'h0, 4'h0, 1, 1));
        vecs.push_back(mk(1, 1, 32'hD3D3D3D3, 4'hF, 1, 0, 3'b111, 3'b111, 1, 3'b000, 3'b000, 32'h0, 4'h0, 0, 1));
        vecs.push_back(mk(1, 0, 32'h0,        4'hF, 0, 0, 3'b111, 3'b111, 1, 3'b000, 3'b000, 32'h0, 4'h0, 0, 1));
        vecs.push_back(mk(1, 1, 32'hE1E1E1E1, 4'hF, 0, 1, 3'b111, 3'b101, 1, 3'b000, 3'b000, 32'h0, 4'h0, 0, 1));
        vecs.push_back(mk(1, 1, 32'hE2E2E2E2, 4'hF, 1, 0, 3'b111, 3'b101, 1, 3'b000, 3'b000, 32'h0, 4'h0, 1, 2));
        vecs.push_back(mk(1, 0, 32'h0,        4'hF, 0, 0, 3'b111, 3'b111, 1, 3'b000, 3'b000, 32'h0, 4'h0, 0, 2));
        // lane 0 disabled mid-packet: packet completes, next one is dropped
        vecs.push_back(mk(1, 1, 32'hF1F1F1F1, 4'hF, 0, 0, 3'b111, 3'b111, 1, 3'b000, 3'b000, 32'h0, 4'h0, 0, 2));
        vecs.push_back(mk(1, 1, 32'hF2F2F2F2, 4'hF, 0, 0, 3'b111, 3'b110, 1, 3'b001, 3'b000, 32'hF1F1F1F1, 4'hF, 0, 2));
        vecs.push_back(mk(1, 1, 32'hF3F3F3F3, 4'hF, 1, 0, 3'b111, 3'b110, 1, 3'b001, 3'b000, 32'hF2F2F2F2, 4'hF, 0, 2));
        vecs.push_back(mk(1, 1, 32'h61616161, 4'hF, 1, 0, 3'b111, 3'b110, 1, 3'b001, 3'b001, 32'hF3F3F3F3, 4'hF, 0, 2));
        vecs.push_back(mk(1, 0, 32'h0,        4'hF, 0, 0, 3'b111, 3'b111, 1, 3'b000, 3'b000, 32'h0, 4'h0, 1, 3));
        vecs.push_back(mk(1, 0, 32'h0,        4'hF, 0, 0, 3'b111, 3'b111, 1, 3'b000, 3'b000, 32'h0, 4'h0, 0, 3));
        // reset after the 2nd beat of a lane 1 packet, then a beat to lane 2
        vecs.push_back(mk(1, 1, 32'h48480001, 4'hF, 0, 1, 3'b111, 3'b111, 1, 3'b000, 3'b000, 32'h0, 4'h0, 0, 3));
        vecs.push_back(mk(1, 1, 32'h48480002, 4'hF, 0, 1, 3'b111, 3'b111, 1, 3'b010, 3'b000, 32'h48480001, 4'hF, 0, 3));
        vecs.push_back(mk(0, 1, 32'h48480003, 4'hF, 0, 1, 3'b111, 3'b111, 0, 3'b010, 3'b000, 32'h48480002, 4'hF, 0, 3));
        vecs.push_back(mk(1, 1, 32'h4A4A4A4A, 4'h9, 1, 2, 3'b111, 3'b111, 1, 3'b000, 3'b000, 32'h0, 4'h0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,        4'hF, 0, 0, 3'b111, 3'b111, 1, 3'b100, 3'b100, 32'h4A4A4A4A, 4'h9, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,        4'hF, 0, 0, 3'b111, 3'b111, 1, 3'b000, 3'b000, 32'h0, 4'h0, 0, 0));

        // Reset state
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        checkOutput("reset s_tready", 32'(s_if.tready), 32'h0);
        checkOutput("reset m_tvalid", 32'(m_if.tvalid), 32'h0);
        checkOutput("reset m_tdata lane0", m_if.tdata[31:0], 32'h0);
        checkOutput("reset m_tdata lane2", m_if.tdata[95:64], 32'h0);
        checkOutput("reset m_tkeep", 32'(m_if.tkeep), 32'h0);
        checkOutput("reset m_tlast", 32'(m_if.tlast), 32'h0);
        checkOutput("reset decode_err", 32'(s_decode_err), 32'h0);
        checkOutput("reset drop_count", 32'(drop_count), 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge aclk);
            checkRow(i, vecs[i]);
        end

        // 5-beat packet to lane 1 with a ragged ready pattern; beats must
        // arrive complete and in order.
        readyPat = 8'b1011_0010;
        sent = 0;
        rcv  = 0;
        cyc  = 0;
        while (rcv < 5 && cyc < 60) begin
            @(posedge aclk);
            #1;
            s_if.tvalid = (sent < 5);
            s_if.tdata  = 32'h50000000 + 32'(sent);
            s_if.tkeep  = 4'hF;
            s_if.tlast  = (sent == 4);
            s_if.tdest  = 2'd1;
            m_if.tready = {1'b1, readyPat[cyc % 8], 1'b1};
            @(negedge aclk);
            if (s_if.tvalid && s_if.tready) begin
                sent++;
            end
            if (m_if.tvalid[1] && m_if.tready[1]) begin
                checkOutput($sformatf("order beat%0d tdata", rcv), m_if.tdata[63:32], 32'h50000000 + 32'(rcv));
                checkOutput($sformatf("order beat%0d tlast", rcv), 32'(m_if.tlast[1]), 32'(rcv == 4));
                rcv++;
            end
            checkOutput($sformatf("order cyc%0d other lanes idle", cyc), 32'({m_if.tvalid[2], m_if.tvalid[0]}), 32'h0);
            cyc++;
        end
        checkOutput("order beats received", 32'(rcv), 32'd5);
        s_if.tvalid = 1'b0;
        m_if.tready = 3'b111;

        // Drop counter saturates rather than wrapping.
        for (int n = 0; n < 65540; n++) begin
            @(posedge aclk);
            #1;
            s_if.tvalid = 1'b1;
            s_if.tdest  = 2'd3;
            s_if.tlast  = 1'b1;
        end
        @(posedge aclk);
        #1;
        s_if.tvalid = 1'b0;
        @(negedge aclk);
        checkOutput("saturated drop_count", 32'(drop_count), 32'h0000FFFF);
        checkOutput("saturated decode_err", 32'(s_decode_err), 32'h1);
        checkOutput("saturated m_tvalid", 32'(m_if.tvalid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/axis_route_1to3.md
Name: axis_route_1to3

Overview:
- Packet router from one AXI4-Stream slave port to three AXI4-Stream master ports; the inverse of the 3-to-1 stream switch on the same data path.
- The destination of each packet comes from s_axis_tdest, sampled on the first beat of the packet. That destination is held until the beat with tlast.
- Each master lane has a one-entry registered output slice, giving full-throughput registered outputs.
- A packet with an invalid or disabled destination is consumed and discarded, and flagged on s_decode_err.

Parameters:
- DATA_WIDTH, 32, data width per stream in bits; tkeep width = DATA_WIDTH/8.
- DEST_WIDTH, 2, width of s_axis_tdest; values 0..2 are valid, values 3 and above are decode errors.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- s_axis_tvalid  in  1  slave valid.
- s_axis_tready  out  1  slave ready.
- s_axis_tdata  in  DATA_WIDTH  slave data.
- s_axis_tkeep  in  DATA_WIDTH/8  slave byte enables.
- s_axis_tlast  in  1  end of packet.
- s_axis_tdest  in  DEST_WIDTH  destination index; sampled on the first beat only.
- m_axis_tvalid  out  3  per-lane valid.
- m_axis_tready  in  3  per-lane ready.
- m_axis_tdata  out  3*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- m_axis_tkeep  out  3*DATA_WIDTH/8  per-lane byte enables, packed the same way.
- m_axis_tlast  out  3  per-lane tlast.
- m_dest_enable  in  3  per-lane enable; a packet addressed to a disabled lane is dropped.
- s_decode_err  out  1  one-cycle pulse when a dropped packet's first beat is accepted.
- drop_count  out  16  number of dropped packets; saturates at 16'hFFFF.

Behaviour:
- Reset (aresetn=0 at a rising edge of aclk):
  - state=IDLE; all m_axis_tvalid=0; m_axis_tdata, tkeep and tlast=0.
  - s_decode_err=0; drop_count=0.
  - s_axis_tready=0 while aresetn=0.
  - Reset mid-packet abandons the packet. The next beat after reset is treated as a first beat.
- Lane slot i is "free" when m_axis_tvalid[i]=0 or m_axis_tready[i]=1.
- Slot load on an accepted beat:
  - tdata, tkeep and tlast are captured into the selected slot, and m_axis_tvalid[sel] is set on the next edge.
  - Latency is 1 cycle from the s-side handshake to m-side valid.
  - A slot whose beat is taken with no new load clears m_axis_tvalid[i].
  - Unselected slots hold their values.
- States:
  - IDLE (expecting a first beat):
    - dest_ok = (s_axis_tdest<3) && m_dest_enable[s_axis_tdest].
    - If dest_ok: s_axis_tready = slot[tdest] free. On accept, sel<=tdest and the beat is loaded. If tlast=0, go to ROUTE; else stay in IDLE.
    - If !dest_ok: s_axis_tready=1. The beat is discarded, s_decode_err pulses on the next cycle, and drop_count increments (saturating). If tlast=0, go to DROP; else stay in IDLE.
  - ROUTE:
    - s_axis_tready = slot[sel] free; s_axis_tdest is ignored.
    - An accepted beat with tlast=1 returns to IDLE.
  - DROP:
    - s_axis_tready=1; beats are discarded with no error pulse.
    - tlast=1 returns to IDLE.
- m_dest_enable changes take effect only at the next first beat; a packet in flight is never truncated.
- Single-beat packets (tlast on the first beat) need no state change.
- Back-to-back packets to different lanes run with no bubble, provided the new slot is free.
- Ordering and stalls:
  - Beats within a packet reach their lane in order.
  - A stalled lane back-pressures only through s_axis_tready; other lanes continue draining their slots.
- tkeep is passed through unmodified. No AXI rule is checked on tkeep.
- s_axis_tvalid=0 never changes state.

Test Plan:
- Reset, then a 4-beat packet with tdest=1, data 0x11111111..0x11111114, all m_tready=1 → lane1 valid on cycles 1-4 after the first accept with the same data; tlast on the 4th beat; lanes 0 and 2 stay invalid.
- Single-beat packets tdest=0, 2, 1 back-to-back, all ready → s_tready held at 1; each lane shows one beat with tlast=1 one cycle after its accept; no bubbles.
- Lane 2 with m_tready=0, 3-beat packet to lane 2 → first beat lands in the slot, then s_tready=0. After m_tready[2] rises, the remaining beats flow one per cycle; lane 0 traffic is unaffected beforehand.
- tdest=3, 3-beat packet → s_tready=1 throughout; no m_tvalid; s_decode_err pulses once; drop_count=1. Repeat with m_dest_enable=3'b101 and tdest=1 → drop_count=2.
- m_dest_enable[0] cleared during the 2nd beat of a 3-beat packet to lane 0 → all 3 beats are delivered. The next packet to lane 0 is dropped with an error pulse.
- aresetn=0 for 1 cycle after the 2nd beat of a 4-beat packet to lane1 → all m_tvalid=0 and drop_count=0. The next beat with tdest=2 routes to lane 2.
